jk_register_bank: RTL and testbench
===================================

JK_REGISTER_BANK -- requirements
Module: jk_register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of JK cells in the bank.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the change-event counter.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Preset, input, 1 bit: synchronous, active-high set of every q bit to 1.
REQ-006 The block SHALL have port En, input, 1 bit: cell update enable.
REQ-007 The block SHALL have port Mode, input, 2 bits: 00 JK, 01 D-load, 10 T-toggle, 11 shift-left.
REQ-008 The block SHALL have ports J and K, input, WIDTH bits each: per-cell control vectors.
REQ-009 The block SHALL have port Clr_cnt, input, 1 bit: synchronous clear of ev_cnt.
REQ-010 The block SHALL have port q, output, WIDTH bits: registered cell states.
REQ-011 The block SHALL have ports rise and fall, output, WIDTH bits each: registered one-cycle edge pulses per cell.
REQ-012 The block SHALL have port ev_cnt, output, CNT_W bits: saturating count of cycles in which q changed.
REQ-013 The block SHALL have ports all_zero and all_one, output, 1 bit each: registered flags, q == 0 and q == all ones.

Function
REQ-014 The priority on each rising Clk edge SHALL be Reset > Preset > En; with none asserted, q SHALL hold.
REQ-015 Reset or Preset SHALL fully determine q that cycle; J, K and Mode SHALL be ignored that cycle.
REQ-016 In Mode 00 with En=1, each bit i SHALL update as follows: J=0,K=0 hold; J=0,K=1 clear to 0; J=1,K=0 set to 1; J=1,K=1 invert q[i].
REQ-017 In Mode 01 with En=1, q SHALL load J; K SHALL be ignored.
REQ-018 In Mode 10 with En=1, q[i] SHALL invert where J[i]=1 and hold elsewhere; K SHALL be ignored.
REQ-019 In Mode 11 with En=1, q SHALL become {q[WIDTH-2:0], J[0]}; the MSB SHALL be discarded.
REQ-020 When WIDTH=1, Mode 11 SHALL behave as a D-load of J[0].
REQ-021 The next value of rise[i] SHALL be 1 exactly when q[i] goes 0 to 1 on that edge, and 0 otherwise.
REQ-022 The next value of fall[i] SHALL be 1 exactly when q[i] goes 1 to 0 on that edge, and 0 otherwise.
REQ-023 rise and fall SHALL be valid in the same cycle as the new q, i.e. with zero added latency relative to q.
REQ-024 rise and fall SHALL also pulse for transitions caused by Preset.
REQ-025 rise and fall SHALL NOT pulse for transitions caused by Reset.
REQ-026 ev_cnt SHALL increment by 1 on each edge where next q differs from current q and neither Reset nor Clr_cnt is asserted.
REQ-027 ev_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 When Clr_cnt is asserted in the same cycle as a q change, ev_cnt SHALL become 0; the change SHALL NOT be counted.
REQ-029 all_zero and all_one SHALL reflect the new q in the same cycle as q.
REQ-030 For WIDTH>=1, all_zero and all_one SHALL never both be 1.
REQ-031 Clr_cnt SHALL NOT affect q, rise, fall or the flags.

Reset
REQ-032 Reset SHALL force q=0, rise=0, fall=0, ev_cnt=0, all_zero=1 and all_one=0 on the next rising edge.
REQ-033 Reset asserted mid-operation SHALL discard any pending update in any mode.
REQ-034 Reset asserted together with Preset SHALL yield the Reset values.
REQ-035 The block SHALL have no asynchronous behaviour; outputs before the first Reset edge are undefined.

Verification
REQ-036 WIDTH=8, Reset, then Mode 00, En=1, J=8'hF0, K=8'h0F -> q=F0, rise=F0, fall=00, ev_cnt=1, all_zero=0.
REQ-037 From q=F0, Mode 00, J=K=8'hFF for 3 cycles -> q: 0F, F0, 0F; ev_cnt reaches 4; rise and fall alternate between F0 and 0F.
REQ-038 From q=00, Mode 11, J[0]=1 for 9 cycles -> q: 01, 03, ... FF, FF; all_one=1 from cycle 8; ev_cnt=8.
REQ-039 20 changing cycles with CNT_W=4 -> ev_cnt stops at 15; Clr_cnt together with a change -> ev_cnt=0.
REQ-040 Reset and Preset both asserted while in Mode 10 with J=FF -> q=00, rise=fall=00, all_zero=1; next cycle Preset only -> q=FF, rise=FF, ev_cnt=1.
REQ-041 En=0 with random J, K and Mode for 10 cycles -> q stable, rise=fall=0, ev_cnt unchanged.

Source files
------------

// File: rtl/jk_register_bank.sv
// jk_register_bank -- bank of WIDTH JK-style cells with a shared mode select,
// registered edge pulses, a saturating change-event counter and all-zero /
// all-one flags.
//
// Ports:
//   Clk       rising-edge clock; every state element updates on it
//   Reset     synchronous active-high reset (q=0, pulses=0, count=0, all_zero=1)
//   Preset    synchronous active-high set of every q bit (below Reset in priority)
//   En        cell update enable (below Preset in priority)
//   Mode      00 JK, 01 D-load of J, 10 toggle where J=1, 11 shift-left with J[0] in
//   J, K      per-cell control vectors
//   Clr_cnt   synchronous clear of ev_cnt; does not touch q, pulses or flags
//   q         registered cell states
//   rise/fall one-cycle pulses, aligned with the new q, for 0->1 / 1->0 changes
//   ev_cnt    saturating count of edges on which q changed
//   all_zero  registered (q == 0), aligned with q
//   all_one   registered (q == all ones), aligned with q

// Per-cell next-state function used when En is the winning control.
module jk_cell (
    input  logic       q_cur,
    input  logic       j,
    input  logic       k,
    input  logic       shift_in,
    input  logic [1:0] mode,
    output logic       q_nxt
);
    always_comb begin
        q_nxt = q_cur;
        case (mode)
            2'b00: begin
                case ({j, k})
                    2'b01:   q_nxt = 1'b0;
                    2'b10:   q_nxt = 1'b1;
                    2'b11:   q_nxt = ~q_cur;
                    default: q_nxt = q_cur;
                endcase
            end
            2'b01:   q_nxt = j;
            2'b10:   q_nxt = q_cur ^ j;
            default: q_nxt = shift_in;
        endcase
    end
endmodule

module jk_register_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Preset,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             Clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [CNT_W-1:0] ev_cnt,
    output logic             all_zero,
    output logic             all_one
);
    logic [WIDTH-1:0] cell_nxt;
    logic [WIDTH-1:0] q_d, q_q;
    logic [WIDTH-1:0] rise_d, rise_q;
    logic [WIDTH-1:0] fall_d, fall_q;
    logic [CNT_W-1:0] ev_cnt_d, ev_cnt_q;
    logic             all_zero_d, all_zero_q;
    logic             all_one_d, all_one_q;

    // Cell 0 shifts in J[0]; higher cells take their lower neighbour. With
    // WIDTH=1 this makes mode 11 a plain load of J[0].
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shift_in;
        if (i == 0) begin : g_lsb
            assign shift_in = J[0];
        end else begin : g_upper
            assign shift_in = q_q[i-1];
        end
        jk_cell u_cell (
            .q_cur    (q_q[i]),
            .j        (J[i]),
            .k        (K[i]),
            .shift_in (shift_in),
            .mode     (Mode),
            .q_nxt    (cell_nxt[i])
        );
    end

    // Reset is applied in the register process; these values cover every
    // other case, including Preset, whose transitions do produce pulses.
    always_comb begin
        q_d = q_q;
        if (Preset)  q_d = '1;
        else if (En) q_d = cell_nxt;

        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;

        ev_cnt_d = ev_cnt_q;
        if (Clr_cnt)                            ev_cnt_d = '0;
        else if (q_d != q_q && ev_cnt_q != '1)  ev_cnt_d = ev_cnt_q + CNT_W'(1);

        all_zero_d = (q_d == '0);
        all_one_d  = (q_d == '1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q        <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            ev_cnt_q   <= '0;
            all_zero_q <= 1'b1;
            all_one_q  <= 1'b0;
        end else begin
            q_q        <= q_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            ev_cnt_q   <= ev_cnt_d;
            all_zero_q <= all_zero_d;
            all_one_q  <= all_one_d;
        end
    end

    assign q        = q_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign ev_cnt   = ev_cnt_q;
    assign all_zero = all_zero_q;
    assign all_one  = all_one_q;
endmodule

// File: tb/tb_jk_register_bank.sv
// Testbench for jk_register_bank (WIDTH=8, CNT_W=4): directed sequences plus
// randomized traffic; a driver pushes expected results from a behavioural
// model into a queue and a monitor pops and compares after each clock edge.
module tb_jk_register_bank;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0, Preset = 1'b0, En = 1'b0, Clr_cnt = 1'b0;
    logic [1:0]    Mode = 2'b00;
    logic [W-1:0]  J = '0, K = '0;
    logic [W-1:0]  q, rise, fall;
    logic [CW-1:0] ev_cnt;
    logic          all_zero, all_one;

    jk_register_bank #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Preset(Preset), .En(En), .Mode(Mode),
        .J(J), .K(K), .Clr_cnt(Clr_cnt), .q(q), .rise(rise), .fall(fall),
        .ev_cnt(ev_cnt), .all_zero(all_zero), .all_one(all_one)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] q, rise, fall;
        int           cnt;
        logic         az, ao;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    logic [W-1:0] mq = '0;
    int     mcnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: applies the cell rules bit by bit from the
    // description, then derives pulses, counter and flags from old/new q.
    task automatic step(input bit rst, input bit pre, input bit en,
                        input logic [1:0] md, input logic [W-1:0] j,
                        input logic [W-1:0] k, input bit clr);
        exp_t e;
        logic [W-1:0] nq;
        @(negedge Clk);
        Reset = rst; Preset = pre; En = en; Mode = md; J = j; K = k; Clr_cnt = clr;
        nq = mq;
        if (pre) nq = '1;
        else if (en) begin
            for (int i = 0; i < W; i++) begin
                case (md)
                    2'd0: if (j[i] && k[i]) nq[i] = !mq[i];
                          else if (j[i]) nq[i] = 1'b1;
                          else if (k[i]) nq[i] = 1'b0;
                    2'd1: nq[i] = j[i];
                    2'd2: if (j[i]) nq[i] = !mq[i];
                    default: nq[i] = (i == 0) ? j[0] : mq[i-1];
                endcase
            end
        end
        if (rst) begin
            nq = '0;
            e.rise = '0; e.fall = '0; mcnt = 0;
        end else begin
            e.rise = nq & ~mq;
            e.fall = mq & ~nq;
            if (clr) mcnt = 0;
            else if (nq != mq && mcnt < (1 << CW) - 1) mcnt++;
        end
        e.q = nq; e.cnt = mcnt;
        e.az = (nq == 0);
        e.ao = (nq == {W{1'b1}});
        mq = nq;
        sb.push_back(e);
    endtask

    // Monitor: every edge after stimulus was issued produces one response.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q",        int'(q),        int'(e.q));
                chk("rise",     int'(rise),     int'(e.rise));
                chk("fall",     int'(fall),     int'(e.fall));
                chk("ev_cnt",   int'(ev_cnt),   e.cnt);
                chk("all_zero", int'(all_zero), int'(e.az));
                chk("all_one",  int'(all_one),  int'(e.ao));
                chk("flags_excl", int'(all_zero & all_one), 0);
            end
        end
    end

    initial begin
        // Reset, then JK set/clear mix
        step(1, 0, 0, 2'd0, 8'h00, 8'h00, 0);
        step(0, 0, 1, 2'd0, 8'hF0, 8'h0F, 0);
        // J=K=FF toggles three times
        repeat (3) step(0, 0, 1, 2'd0, 8'hFF, 8'hFF, 0);
        // Shift in ones from zero for 9 cycles
        step(1, 0, 0, 2'd0, 8'h00, 8'h00, 0);
        repeat (9) step(0, 0, 1, 2'd3, 8'h01, 8'h00, 0);
        // 20 changing cycles saturate the counter, then clear with a change
        repeat (20) step(0, 0, 1, 2'd2, 8'h01, 8'h00, 0);
        step(0, 0, 1, 2'd2, 8'h01, 8'h00, 1);
        // Reset with Preset in toggle mode, then Preset alone
        step(1, 1, 1, 2'd2, 8'hFF, 8'h00, 0);
        step(0, 1, 1, 2'd2, 8'hFF, 8'h00, 0);
        // D-load a pattern, then En=0 with random controls
        step(0, 0, 1, 2'd1, 8'hA5, 8'h3C, 0);
        repeat (10) step(0, 0, 0, 2'($urandom), 8'($urandom), 8'($urandom), 0);
        // Randomized traffic including occasional Reset/Preset/Clr_cnt
        repeat (400) step(($urandom % 20) == 0, ($urandom % 15) == 0,
                          ($urandom % 4) != 0, 2'($urandom),
                          8'($urandom), 8'($urandom), ($urandom % 10) == 0);
        step(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
        repeat (3) @(posedge Clk);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
